pixel_mem_write: RTL and testbench

Frame-memory writer: the producing end of the pixel-memory interface whose consuming end is the VGA fetch path. Accepts a stream of 18-bit YCrCb pixels tagged with (x, y), packs horizontally adjacent pairs into one `LOG_MEM`-bit (36-bit) word, addresses it in the same 320-words-per-line layout the VGA reader uses, and delivers it to the memory interface with a flag/done handshake. Sits between the capture/transform pipeline and the memory arbiter.

---
 rtl/pixel_mem_write_pkg.sv | 30 +++
 rtl/pixel_mem_write_word_fifo.sv | 48 ++++
 rtl/pixel_mem_write.sv | 179 +++++++++++++++++
 tb/tb_pixel_mem_write.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_write_pkg.sv
// Shared widths, memory word payload and write FSM states for the frame-memory writer.
package pixel_mem_write_pkg;

   localparam int unsigned LOG_MEM       = 36;
   localparam int unsigned LOG_PIX       = 18;
   localparam int unsigned LOG_HCOUNT    = 10;
   localparam int unsigned LOG_VCOUNT    = 10;
   localparam int unsigned LOG_ADDR      = 19;
   localparam int unsigned LOG_LINE_ADDR = LOG_ADDR - 1;
   localparam int unsigned LOG_XWORD     = LOG_HCOUNT - 1;
   localparam int unsigned VGA_HACTIVE   = 640;
   localparam int unsigned VGA_VACTIVE   = 480;

   typedef struct packed {
      logic [LOG_ADDR-1:0] addr;
      logic [LOG_MEM-1:0]  data;
   } mem_word_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_WAIT = 1'b1
   } wr_state_t;

   // y*320 + x/2 built from y*256 + y*64, no multiplier
   function automatic logic [LOG_LINE_ADDR-1:0] word_addr(input logic [LOG_VCOUNT-1:0] y,
                                                          input logic [LOG_XWORD-1:0]  xw);
      return LOG_LINE_ADDR'({y, 8'b0}) + LOG_LINE_ADDR'({y, 6'b0}) + LOG_LINE_ADDR'(xw);
   endfunction

endpackage

// File: rtl/pixel_mem_write_word_fifo.sv
// Synchronous first-word-fall-through FIFO; a push on a full FIFO is taken only alongside a pop.
module word_fifo #(
   parameter int unsigned WIDTH     = 55,
   parameter int unsigned LOG_DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data_c,
   output logic             full_c,
   output logic             empty_c
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam int unsigned CW    = LOG_DEPTH + 1;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic [CW-1:0]        count;
   logic                 do_push;
   logic                 do_pop;

   assign full_c     = (count == CW'(DEPTH));
   assign empty_c    = (count == '0);
   assign do_push    = push && (!full_c || pop);
   assign do_pop     = pop && !empty_c;
   assign pop_data_c = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/pixel_mem_write.sv
// Frame-memory writer: pairs pixels into 36-bit words, queues them and hands them to memory.
// PIXEL_WRITE_DOUBLE_BUFFER_EN selects double buffering via the write_addr MSB.
module pixel_mem_write
   import pixel_mem_write_pkg::*;
#(
   parameter int unsigned FIFO_LOG       = 2,
   parameter int unsigned WORDS_PER_LINE = 320
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pix_valid,
   input  logic [LOG_PIX-1:0]    pix_ycrcb,
   input  logic [LOG_HCOUNT-1:0] pix_x,
   input  logic [LOG_VCOUNT-1:0] pix_y,
   input  logic                  pix_frame_end,
   output logic                  write_flag,
   output logic [LOG_MEM-1:0]    write_pixel,
   output logic [LOG_ADDR-1:0]   write_addr,
   input  logic                  done_write,
   output logic                  frame_flag,
   output logic                  overflow
);

   logic                  half_valid;
   logic [LOG_PIX-1:0]    half_data;
   logic [LOG_XWORD-1:0]  half_xw;
   logic [LOG_VCOUNT-1:0] half_y;
   logic                  pix_ok;
   logic                  pair_hit;
   logic                  pair_valid;
   logic [LOG_MEM-1:0]    pair_data;
   logic [LOG_XWORD-1:0]  pair_xw;
   logic [LOG_VCOUNT-1:0] pair_y;
   logic                  push_valid;
   mem_word_t             push_word;
   mem_word_t             pop_word;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic                  pending;
   logic                  buf_sel;
   logic                  commit;
   wr_state_t             wr_state;
   wr_state_t             wr_state_next;
   logic                  flag_next;
   logic                  frame_next;
   logic [LOG_MEM-1:0]    pixel_next;
   logic [LOG_ADDR-1:0]   addr_next;

   assign pix_ok   = pix_valid && (pix_x < LOG_HCOUNT'(2 * WORDS_PER_LINE))
                               && (pix_y < LOG_VCOUNT'(VGA_VACTIVE));
   assign pair_hit = pix_ok && pix_x[0] && half_valid
                     && (pix_x[LOG_HCOUNT-1:1] == half_xw) && (pix_y == half_y);

   // Even-pixel half register
   always_ff @(posedge clock) begin
      if (!reset) begin
         half_valid <= 1'b0;
         half_data  <= '0;
         half_xw    <= '0;
         half_y     <= '0;
      end else if (pix_frame_end) begin
         half_valid <= 1'b0;
      end else if (pix_ok && !pix_x[0]) begin
         half_valid <= 1'b1;
         half_data  <= pix_ycrcb;
         half_xw    <= pix_x[LOG_HCOUNT-1:1];
         half_y     <= pix_y;
      end else if (pair_hit) begin
         half_valid <= 1'b0;
      end
   end

   // Completed pair, then address stage feeding the FIFO
   always_ff @(posedge clock) begin
      if (!reset) begin
         pair_valid <= 1'b0;
         pair_data  <= '0;
         pair_xw    <= '0;
         pair_y     <= '0;
         push_valid <= 1'b0;
         push_word  <= '0;
      end else begin
         pair_valid <= pair_hit;
         if (pair_hit) begin
            pair_data <= {pix_ycrcb, half_data};
            pair_xw   <= pix_x[LOG_HCOUNT-1:1];
            pair_y    <= pix_y;
         end
         push_valid <= pair_valid;
         if (pair_valid) push_word <= '{addr: {buf_sel, word_addr(pair_y, pair_xw)}, data: pair_data};
      end
   end

   word_fifo #(
      .WIDTH     ($bits(mem_word_t)),
      .LOG_DEPTH (FIFO_LOG)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push_valid),
      .push_data  (push_word),
      .pop        (fifo_pop),
      .pop_data_c (pop_word),
      .full_c     (fifo_full),
      .empty_c    (fifo_empty)
   );

`ifdef PIXEL_WRITE_DOUBLE_BUFFER_EN
   logic buffer;

   always_ff @(posedge clock) begin
      if (!reset)      buffer <= 1'b0;
      else if (commit) buffer <= ~buffer;
   end

   assign buf_sel = buffer;
`else
   assign buf_sel = 1'b0;
`endif

   // Frame-end pending flag and sticky overflow
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (commit)             pending <= 1'b0;
         else if (pix_frame_end) pending <= 1'b1;
         if (push_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_state    <= WR_IDLE;
         write_flag  <= 1'b0;
         write_pixel <= '0;
         write_addr  <= '0;
         frame_flag  <= 1'b0;
      end else begin
         wr_state    <= wr_state_next;
         write_flag  <= flag_next;
         write_pixel <= pixel_next;
         write_addr  <= addr_next;
         frame_flag  <= frame_next;
      end
   end

   // Frames commit only once the pairing pipeline and FIFO have fully drained
   always_comb begin
      wr_state_next = wr_state;
      fifo_pop      = 1'b0;
      flag_next     = 1'b0;
      frame_next    = 1'b0;
      commit        = 1'b0;
      pixel_next    = write_pixel;
      addr_next     = write_addr;
      case (wr_state)
         WR_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop      = 1'b1;
               flag_next     = 1'b1;
               pixel_next    = pop_word.data;
               addr_next     = pop_word.addr;
               wr_state_next = WR_WAIT;
            end else if (pending && !pair_valid && !push_valid) begin
               frame_next = 1'b1;
               commit     = 1'b1;
            end
         end
         WR_WAIT: begin
            if (done_write) wr_state_next = WR_IDLE;
         end
         default: wr_state_next = WR_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pixel_mem_write.sv
// Self-checking bench for pixel_mem_write: directed scenarios plus randomized pixels vs a queue model.
module tb_pixel_mem_write;
   import pixel_mem_write_pkg::*;

`ifdef PIXEL_WRITE_DOUBLE_BUFFER_EN
   localparam bit DBUF = 1'b1;
`else
   localparam bit DBUF = 1'b0;
`endif

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  pix_valid = 1'b0;
   logic [LOG_PIX-1:0]    pix_ycrcb = '0;
   logic [LOG_HCOUNT-1:0] pix_x = '0;
   logic [LOG_VCOUNT-1:0] pix_y = '0;
   logic                  pix_frame_end = 1'b0;
   logic                  write_flag;
   logic [LOG_MEM-1:0]    write_pixel;
   logic [LOG_ADDR-1:0]   write_addr;
   logic                  done_write = 1'b0;
   logic                  frame_flag;
   logic                  overflow;

   int total = 0;
   int bad   = 0;

   pixel_mem_write #(.FIFO_LOG(2), .WORDS_PER_LINE(320)) dut (
      .clock         (clock),
      .reset         (reset),
      .pix_valid     (pix_valid),
      .pix_ycrcb     (pix_ycrcb),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_frame_end (pix_frame_end),
      .write_flag    (write_flag),
      .write_pixel   (write_pixel),
      .write_addr    (write_addr),
      .done_write    (done_write),
      .frame_flag    (frame_flag),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; pix_valid = 1'b0; pix_frame_end = 1'b0; done_write = 1'b0;
      tick; tick;
      reset = 1'b1;
   endtask

   task automatic drive_pix(input int x, input int y, input logic [17:0] d);
      pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y); pix_ycrcb = d;
      tick;
      pix_valid = 1'b0;
   endtask

   task automatic pulse_frame_end;
      pix_frame_end = 1'b1; tick; pix_frame_end = 1'b0;
   endtask

   task automatic ack;
      done_write = 1'b1; tick; done_write = 1'b0;
   endtask

   task automatic wait_write(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (write_flag) seen = 1'b1;
         else tick;
      end
   endtask

   task automatic count_writes(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick;
         if (write_flag) n++;
      end
   endtask

   function automatic logic [LOG_ADDR-1:0] exp_addr(input int x, input int y, input bit b);
      return {b, 18'(y * 320 + x / 2)};
   endfunction

   function automatic logic [17:0] rnd_pix();
      return 18'($urandom);
   endfunction

   task automatic test_reset;
      reset = 1'b0; pix_valid = 1'b1; pix_x = 10'd1; done_write = 1'b1; pix_frame_end = 1'b1;
      tick; tick;
      pix_valid = 1'b0; done_write = 1'b0; pix_frame_end = 1'b0;
      total += 5;
      if (write_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", write_flag); end
      if (write_pixel !== '0) begin bad++; $display("FAIL reset_pixel got=%h want=0", write_pixel); end
      if (write_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", write_addr); end
      if (frame_flag !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", frame_flag); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      reset = 1'b1;
   endtask

   task automatic test_basic;
      bit seen;
      int n;
      logic [LOG_MEM-1:0] held;
      do_reset;
      drive_pix(0, 0, 18'h00001);
      drive_pix(1, 0, 18'h00002);
      wait_write(10, seen);
      total += 3;
      if (!seen) begin bad++; $display("FAIL basic_flag got=none want=write_flag"); end
      if (write_pixel !== 36'h000080001) begin bad++; $display("FAIL basic_data got=%h want=%h", write_pixel, 36'h000080001); end
      if (write_addr !== 19'd0) begin bad++; $display("FAIL basic_addr got=%h want=0", write_addr); end
      held = write_pixel;
      tick;
      total += 1;
      if (write_flag !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", write_flag); end
      tick; tick;
      total += 1;
      if (write_pixel !== held) begin bad++; $display("FAIL basic_hold got=%h want=%h", write_pixel, held); end
      ack;
      count_writes(10, n);
      total += 1;
      if (n !== 0) begin bad++; $display("FAIL basic_extra got=%0d want=0", n); end
   endtask

   task automatic test_corner;
      bit seen;
      logic [17:0] d0, d1;
      d0 = rnd_pix(); d1 = rnd_pix();
      do_reset;
      drive_pix(638, 479, d0);
      drive_pix(639, 479, d1);
      wait_write(10, seen);
      total += 2;
      if (!seen || write_addr !== 19'd153599) begin bad++; $display("FAIL corner_addr got=%h want=%h", write_addr, 19'd153599); end
      if (write_pixel !== {d1, d0}) begin bad++; $display("FAIL corner_data got=%h want=%h", write_pixel, {d1, d0}); end
      ack;
   endtask

   task automatic test_drop_frame;
      int n;
      logic f0, f1, f2;
      do_reset;
      drive_pix(5, 0, rnd_pix());
      drive_pix(6, 0, rnd_pix());
      drive_pix(700, 0, rnd_pix());
      drive_pix(701, 0, rnd_pix());
      drive_pix(3, 480, rnd_pix());
      pulse_frame_end;
      f0 = frame_flag; tick;
      f1 = frame_flag; tick;
      f2 = frame_flag;
      total += 3;
      if (f0 !== 1'b0) begin bad++; $display("FAIL frame_early got=%b want=0", f0); end
      if (f1 !== 1'b1) begin bad++; $display("FAIL frame_pulse got=%b want=1", f1); end
      if (f2 !== 1'b0) begin bad++; $display("FAIL frame_width got=%b want=0", f2); end
      drive_pix(7, 0, rnd_pix());
      count_writes(10, n);
      total += 1;
      if (n !== 0) begin bad++; $display("FAIL drop_writes got=%0d want=0", n); end
   endtask

   task automatic test_overflow;
      bit seen;
      int n;
      logic [54:0] q[$];
      logic [54:0] w;
      logic [17:0] e, o;
      do_reset;
      e = rnd_pix(); o = rnd_pix();
      drive_pix(0, 10, e);
      drive_pix(1, 10, o);
      wait_write(10, seen);
      total += 1;
      if (!seen || {write_addr, write_pixel} !== {exp_addr(0, 10, 1'b0), o, e}) begin
         bad++; $display("FAIL ovf_first got=%h want=%h", {write_addr, write_pixel}, {exp_addr(0, 10, 1'b0), o, e});
      end
      for (int k = 0; k < 6; k++) begin
         e = rnd_pix(); o = rnd_pix();
         drive_pix(2 + 2 * k, 10, e);
         drive_pix(3 + 2 * k, 10, o);
         if (k < 4) q.push_back({exp_addr(2 + 2 * k, 10, 1'b0), o, e});
      end
      repeat (5) tick;
      total += 1;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
      for (int k = 0; k < 4; k++) begin
         ack;
         wait_write(10, seen);
         w = q.pop_front();
         total += 1;
         if (!seen || {write_addr, write_pixel} !== w) begin
            bad++; $display("FAIL ovf_word%0d got=%h want=%h", k, {write_addr, write_pixel}, w);
         end
      end
      ack;
      count_writes(10, n);
      total += 2;
      if (n !== 0) begin bad++; $display("FAIL ovf_extra got=%0d want=0", n); end
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
   endtask

   task automatic test_buffers;
      bit seen;
      bit b;
      int cyc;
      logic [17:0] e, o;
      do_reset;
      b = 1'b0;
      for (int f = 0; f < 3; f++) begin
         if (f > 0) begin
            pulse_frame_end;
            cyc = 0;
            while (!frame_flag && cyc < 20) begin tick; cyc++; end
            total += 1;
            if (!frame_flag) begin bad++; $display("FAIL buf_frame%0d got=0 want=1", f); end
            if (DBUF) b = ~b;
            tick;
         end
         e = rnd_pix(); o = rnd_pix();
         drive_pix(10, f + 1, e);
         drive_pix(11, f + 1, o);
         wait_write(10, seen);
         total += 1;
         if (!seen || write_addr !== exp_addr(10, f + 1, b)) begin
            bad++; $display("FAIL buf_addr%0d got=%h want=%h", f, write_addr, exp_addr(10, f + 1, b));
         end
         ack;
      end
   endtask

   task automatic test_reset_in_wait;
      bit seen;
      int n;
      do_reset;
      drive_pix(0, 5, rnd_pix());
      drive_pix(1, 5, rnd_pix());
      wait_write(10, seen);
      drive_pix(2, 5, rnd_pix());
      drive_pix(3, 5, rnd_pix());
      tick; tick; tick;
      reset = 1'b0;
      tick;
      total += 4;
      if (write_flag !== 1'b0) begin bad++; $display("FAIL rstw_flag got=%b want=0", write_flag); end
      if (write_pixel !== '0) begin bad++; $display("FAIL rstw_pixel got=%h want=0", write_pixel); end
      if (write_addr !== '0) begin bad++; $display("FAIL rstw_addr got=%h want=0", write_addr); end
      if (frame_flag !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rstw_misc got=%b%b want=00", frame_flag, overflow); end
      reset = 1'b1;
      ack;
      count_writes(12, n);
      total += 1;
      if (n !== 0) begin bad++; $display("FAIL rstw_late got=%0d want=0", n); end
   endtask

   task automatic test_random;
      logic [54:0] q[$];
      logic [54:0] w;
      bit drv_done;
      bit hv;
      int hx, hy;
      logic [17:0] hd;
      int n;
      do_reset;
      drv_done = 1'b0;
      hv = 1'b0; hx = 0; hy = 0; hd = '0;
      fork
         begin
            for (int ev = 0; ev < 60; ev++) begin
               int t, x, y, npix;
               int xs[2];
               t = $urandom_range(0, 9);
               y = $urandom_range(0, 479);
               x = 2 * $urandom_range(0, 319);
               npix = 2;
               case (t)
                  6: begin xs[0] = x + 1; npix = 1; end
                  7: begin xs[0] = x; npix = 1; end
                  8: begin xs[0] = 640 + x / 4; xs[1] = 641 + x / 4; end
                  9: begin xs[0] = $urandom_range(0, 639); npix = 1; end
                  default: begin xs[0] = x; xs[1] = x + 1; end
               endcase
               for (int p = 0; p < npix; p++) begin
                  logic [17:0] d;
                  d = rnd_pix();
                  if (xs[p] < 640 && y < 480) begin
                     if (xs[p] % 2 == 0) begin
                        hv = 1'b1; hx = xs[p]; hy = y; hd = d;
                     end else if (hv && xs[p] == hx + 1 && y == hy) begin
                        q.push_back({exp_addr(xs[p], y, 1'b0), d, hd});
                        hv = 1'b0;
                     end
                  end
                  drive_pix(xs[p], y, d);
               end
               repeat ($urandom_range(6, 9)) tick;
            end
            drv_done = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while (!(drv_done && q.size() == 0) && cyc < 20000) begin
               if (write_flag) begin
                  total++;
                  if (q.size() == 0) begin
                     bad++; $display("FAIL rand_unexpected got=%h want=none", {write_addr, write_pixel});
                  end else begin
                     w = q.pop_front();
                     if ({write_addr, write_pixel} !== w) begin
                        bad++; $display("FAIL rand_word got=%h want=%h", {write_addr, write_pixel}, w);
                     end
                  end
                  repeat ($urandom_range(0, 3)) tick;
                  ack;
               end else begin
                  tick;
               end
               cyc++;
            end
            if (cyc >= 20000) begin
               total++; bad++;
               $display("FAIL rand_timeout got=%0d pending want=0", q.size());
            end
         end
      join
      count_writes(10, n);
      total += 2;
      if (n !== 0) begin bad++; $display("FAIL rand_extra got=%0d want=0", n); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b want=0", overflow); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_corner;
      test_drop_frame;
      test_overflow;
      test_buffers;
      test_reset_in_wait;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
